// File: rtl/udp_cmd_dispatcher.sv
// udp_cmd_dispatcher: parse UDP RX payload bytes into fixed 9-byte command frames and issue them over valid/ready
// Ports:
//   udp_rx_clk, reset (async, active-low)
//   app_rx_data_valid/app_rx_data/app_rx_data_length : RX payload byte stream
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data     : one-deep command slot
//   busy                                             : frame parsing in progress
//   good_cnt/err_cnt/drop_cnt                        : issued / rejected / lost-to-full-slot frames
module udp_cmd_dispatcher #(
  parameter logic [15:0] MAGIC     = 16'hA55A,
  parameter int          FRAME_LEN = 9
) (
  input  logic        udp_rx_clk,
  input  logic        reset,
  input  logic        app_rx_data_valid,
  input  logic [7:0]  app_rx_data,
  input  logic [15:0] app_rx_data_length,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        busy,
  output logic [15:0] good_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, BODY, CHK, DRAIN} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_idx, r_len, w_len_raw, w_len;
  logic [7:0]  r_xor;
  logic [47:0] r_sh;
  logic        r_bad, w_bad, w_last, w_ok, w_free;
  logic        r_eof, r_eof_ok;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_op, r_cmd_addr, r_err_cnt, r_drop_cnt;
  logic [31:0] r_cmd_data;
  logic [15:0] r_good_cnt;
  // Length is only sampled on byte 0; a zero length still describes a one-byte packet
  assign w_len_raw = (r_idx == 16'd0) ? app_rx_data_length : r_len;
  assign w_len     = (w_len_raw == 16'd0) ? 16'd1 : w_len_raw;
  assign w_last    = r_idx == w_len - 16'd1;
  assign w_free    = !r_cmd_valid || cmd_ready;
  always_ff @(posedge udp_rx_clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else if (app_rx_data_valid) r_state <= w_next;
  always_comb
    w_next = w_last ? IDLE :
             r_state == IDLE ? HDR :
             r_state == HDR  ? BODY :
             r_state == BODY ? (r_idx == 16'd7 ? CHK : BODY) : DRAIN;
  // Bad-frame verdict including the byte currently on the bus; only a frame
  // that has reached the checksum byte can be good
  always_comb begin
    w_bad = r_state == IDLE ? (w_len < 16'(FRAME_LEN) || app_rx_data != MAGIC[15:8]) :
            r_state == HDR  ? (r_bad || app_rx_data != MAGIC[7:0]) :
            r_state == CHK  ? (r_bad || app_rx_data != r_xor) : r_bad;
    w_ok  = !w_bad && (r_state == CHK || r_state == DRAIN);
  end
  always_ff @(posedge udp_rx_clk or negedge reset)
    if (!reset) begin
      r_idx    <= '0;
      r_len    <= '0;
      r_xor    <= '0;
      r_bad    <= 1'b0;
      r_sh     <= '0;
      r_eof    <= 1'b0;
      r_eof_ok <= 1'b0;
    end else begin
      r_eof    <= app_rx_data_valid && w_last;
      r_eof_ok <= w_ok;
      if (app_rx_data_valid) begin
        r_idx <= w_last ? 16'd0 : r_idx + 16'd1;
        if (r_idx == 16'd0) r_len <= app_rx_data_length;
        r_xor <= (r_idx == 16'd0) ? app_rx_data : r_xor ^ app_rx_data;
        r_bad <= w_bad;
        if (r_state == BODY) r_sh <= {r_sh[39:0], app_rx_data};
      end
    end
  // End-of-frame evaluation one cycle after the last byte; shadow bytes 2..7
  // cannot be overwritten by a back-to-back packet before this completes
  always_ff @(posedge udp_rx_clk or negedge reset)
    if (!reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_good_cnt  <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_eof && r_eof_ok && w_free) begin
        r_cmd_valid <= 1'b1;
        r_cmd_op    <= r_sh[47:40];
        r_cmd_addr  <= r_sh[39:32];
        r_cmd_data  <= r_sh[31:0];
        r_good_cnt  <= r_good_cnt + 16'd1;
      end else if (r_cmd_valid && cmd_ready) r_cmd_valid <= 1'b0;
      if (r_eof && !r_eof_ok && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (r_eof && r_eof_ok && !w_free && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_data  = r_cmd_data;
  assign good_cnt  = r_good_cnt;
  assign err_cnt   = r_err_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_udp_cmd_dispatcher.sv
// tb_udp_cmd_dispatcher: directed self-checking bench for udp_cmd_dispatcher
module tb_udp_cmd_dispatcher;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [7:0]  data;
  logic [15:0] len;
  logic        cmd_valid, cmd_ready, busy;
  logic [7:0]  cmd_op, cmd_addr, err_cnt, drop_cnt;
  logic [31:0] cmd_data;
  logic [15:0] good_cnt;
  logic [7:0]  f [0:15];
  int          n_chk = 0;
  int          n_fail = 0;
  udp_cmd_dispatcher dut (
    .udp_rx_clk(clk), .reset(reset), .app_rx_data_valid(valid), .app_rx_data(data),
    .app_rx_data_length(len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .good_cnt(good_cnt),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic fix_chk();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 8; i++) x ^= f[i];
    f[8] = x;
  endtask
  task automatic build(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] d);
    f[0] = 8'hA5; f[1] = 8'h5A; f[2] = op; f[3] = addr;
    f[4] = d[31:24]; f[5] = d[23:16]; f[6] = d[15:8]; f[7] = d[7:0];
    for (int i = 9; i < 16; i++) f[i] = 8'h77;
    fix_chk();
  endtask
  task automatic send(input int n, input logic [15:0] l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1; data = f[i]; len = l;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0; valid = 1'b0; data = '0; len = '0; cmd_ready = 1'b1;
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_good", good_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk) reset = 1'b1;
    // good 9-byte frame, ready high: one-cycle cmd_valid
    build(8'h01, 8'h10, 32'hDEADBEEF);
    send(9, 16'd9);
    idle(1);
    check("t1_lat0", cmd_valid, 0);
    @(negedge clk);
    check("t1_valid", cmd_valid, 1);
    check("t1_op", cmd_op, 8'h01);
    check("t1_addr", cmd_addr, 8'h10);
    check("t1_data", cmd_data, 32'hDEADBEEF);
    check("t1_good", good_cnt, 1);
    @(negedge clk);
    check("t1_clear", cmd_valid, 0);
    // bad checksum, bad second magic byte, zero length
    f[8] = f[8] ^ 8'h01;
    send(9, 16'd9);
    idle(3);
    check("t2_chk_valid", cmd_valid, 0);
    check("t2_chk_err", err_cnt, 1);
    build(8'h01, 8'h10, 32'hDEADBEEF);
    f[1] = 8'h5B;
    fix_chk();
    send(9, 16'd9);
    idle(3);
    check("t2_magic_err", err_cnt, 2);
    check("t2_good", good_cnt, 1);
    build(8'h01, 8'h10, 32'hDEADBEEF);
    send(1, 16'd0);
    idle(3);
    check("t2_len0_err", err_cnt, 3);
    check("t2_len0_busy", busy, 0);
    // short packet then 12-byte good packet, no gap
    send(6, 16'd6);
    build(8'h02, 8'h20, 32'h12345678);
    send(12, 16'd12);
    idle(1);
    check("t3_err", err_cnt, 4);
    check("t3_lat0", cmd_valid, 0);
    @(negedge clk);
    check("t3_valid", cmd_valid, 1);
    check("t3_op", cmd_op, 8'h02);
    check("t3_addr", cmd_addr, 8'h20);
    check("t3_data", cmd_data, 32'h12345678);
    check("t3_good", good_cnt, 2);
    @(negedge clk);
    check("t3_clear", cmd_valid, 0);
    // slot full: second good frame dropped, first held
    cmd_ready = 1'b0;
    build(8'h03, 8'h30, 32'hA0A0A0A0);
    send(9, 16'd9);
    idle(3);
    check("t4_valid_a", cmd_valid, 1);
    check("t4_op_a", cmd_op, 8'h03);
    build(8'h04, 8'h40, 32'hB1B1B1B1);
    send(9, 16'd9);
    idle(3);
    check("t4_held_valid", cmd_valid, 1);
    check("t4_held_op", cmd_op, 8'h03);
    check("t4_held_data", cmd_data, 32'hA0A0A0A0);
    check("t4_drop", drop_cnt, 1);
    check("t4_good", good_cnt, 3);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("t4_accept", cmd_valid, 0);
    // reset mid-frame after byte 4
    build(8'h0F, 8'hF0, 32'hCAFEF00D);
    send(5, 16'd9);
    @(negedge clk);
    check("t5_busy", busy, 1);
    reset = 1'b0; valid = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_good", good_cnt, 0);
    check("t5_rst_drop", drop_cnt, 0);
    @(negedge clk) reset = 1'b1;
    build(8'h05, 8'h50, 32'h0BADF00D);
    send(9, 16'd9);
    idle(2);
    check("t5_valid", cmd_valid, 1);
    check("t5_op", cmd_op, 8'h05);
    check("t5_data", cmd_data, 32'h0BADF00D);
    check("t5_good", good_cnt, 1);
    check("t5_err", err_cnt, 0);
    // err_cnt saturation with back-to-back one-byte bad packets
    f[0] = 8'h00;
    for (int i = 0; i < 254; i++) send(1, 16'd1);
    idle(2);
    check("t6_err_fe", err_cnt, 8'hFE);
    for (int i = 0; i < 46; i++) send(1, 16'd1);
    idle(2);
    check("t6_err_sat", err_cnt, 8'hFF);
    check("t6_good", good_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
